// File: rtl/mpu_load.sv
// Matrix load engine: streams row-major elements from memory into a matrix register.
// Global width constants shared across the MPU live in the global_defs package.
package global_defs;
   localparam int FPBITS          = 31;
   localparam int MBITS           = 3;
   localparam int NBITS           = 3;
   localparam int MATRIX_REG_BITS = 2;
endpackage

module mpu_load
   import global_defs::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_req_in,
   input  logic [MBITS:0]             mem_m_load_size_in,
   input  logic [NBITS:0]             mem_n_load_size_in,
   input  logic [MATRIX_REG_BITS:0]   mem_load_addr_in,
   input  logic                       mem_load_valid_in,
   input  logic [FPBITS:0]            mem_load_element_in,
   output logic                       mem_load_ready_out,
   output logic                       reg_load_en_out,
   output logic [MBITS:0]             reg_i_load_loc_out,
   output logic [NBITS:0]             reg_j_load_loc_out,
   output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
   output logic [MBITS:0]             reg_m_load_size_out,
   output logic [NBITS:0]             reg_n_load_size_out,
   output logic [FPBITS:0]            reg_load_element_out,
   output logic                       load_busy_out,
   output logic                       load_done_out,
   output logic                       load_error_out
);

   typedef enum logic [1:0] {LOAD_IDLE, LOAD_MATRIX, LOAD_DONE} load_state_t;

   load_state_t      state, next_state;
   logic [MBITS:0]   row_ptr;
   logic [NBITS:0]   col_ptr;
   logic [MBITS:0]   m_last;
   logic [NBITS:0]   n_last;
   logic             req_ok;
   logic             accept;
   logic             at_last;

   // ready_out is a registered copy of (state == LOAD_MATRIX), so it doubles as the accept gate
   assign accept  = mem_load_valid_in && mem_load_ready_out;
   assign req_ok  = load_req_in && (mem_m_load_size_in != '0) && (mem_n_load_size_in != '0);
   assign m_last  = reg_m_load_size_out - 1'b1;
   assign n_last  = reg_n_load_size_out - 1'b1;
   assign at_last = (row_ptr == m_last) && (col_ptr == n_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         LOAD_IDLE:   if (req_ok) next_state = LOAD_MATRIX;
         LOAD_MATRIX: if (accept && at_last) next_state = LOAD_DONE;
         LOAD_DONE:   next_state = LOAD_IDLE;
         default:     next_state = LOAD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_ptr              <= '0;
         col_ptr              <= '0;
         mem_load_ready_out   <= 1'b0;
         reg_load_en_out      <= 1'b0;
         reg_i_load_loc_out   <= '0;
         reg_j_load_loc_out   <= '0;
         reg_load_addr_out    <= '0;
         reg_m_load_size_out  <= '0;
         reg_n_load_size_out  <= '0;
         reg_load_element_out <= '0;
         load_busy_out        <= 1'b0;
         load_done_out        <= 1'b0;
         load_error_out       <= 1'b0;
      end else begin
         mem_load_ready_out <= (next_state == LOAD_MATRIX);
         load_busy_out      <= (next_state != LOAD_IDLE);
         load_done_out      <= (next_state == LOAD_DONE);
         load_error_out     <= (state == LOAD_IDLE) && load_req_in && !req_ok;
         reg_load_en_out    <= accept;

         if ((state == LOAD_IDLE) && req_ok) begin
            reg_m_load_size_out <= mem_m_load_size_in;
            reg_n_load_size_out <= mem_n_load_size_in;
            reg_load_addr_out   <= mem_load_addr_in;
            row_ptr             <= '0;
            col_ptr             <= '0;
         end

         if (accept) begin
            reg_load_element_out <= mem_load_element_in;
            reg_i_load_loc_out   <= row_ptr;
            reg_j_load_loc_out   <= col_ptr;
            if (col_ptr == n_last) begin
               col_ptr <= '0;
               if (row_ptr != m_last) row_ptr <= row_ptr + 1'b1;
            end else begin
               col_ptr <= col_ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mpu_load.sv
// Randomized self-checking bench for mpu_load against a count-based load model.
module tb_mpu_load;
   import global_defs::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     load_req_in;
   logic [MBITS:0]           mem_m_load_size_in;
   logic [NBITS:0]           mem_n_load_size_in;
   logic [MATRIX_REG_BITS:0] mem_load_addr_in;
   logic                     mem_load_valid_in;
   logic [FPBITS:0]          mem_load_element_in;
   logic                     mem_load_ready_out;
   logic                     reg_load_en_out;
   logic [MBITS:0]           reg_i_load_loc_out;
   logic [NBITS:0]           reg_j_load_loc_out;
   logic [MATRIX_REG_BITS:0] reg_load_addr_out;
   logic [MBITS:0]           reg_m_load_size_out;
   logic [NBITS:0]           reg_n_load_size_out;
   logic [FPBITS:0]          reg_load_element_out;
   logic                     load_busy_out;
   logic                     load_done_out;
   logic                     load_error_out;

   mpu_load dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .load_req_in          (load_req_in),
      .mem_m_load_size_in   (mem_m_load_size_in),
      .mem_n_load_size_in   (mem_n_load_size_in),
      .mem_load_addr_in     (mem_load_addr_in),
      .mem_load_valid_in    (mem_load_valid_in),
      .mem_load_element_in  (mem_load_element_in),
      .mem_load_ready_out   (mem_load_ready_out),
      .reg_load_en_out      (reg_load_en_out),
      .reg_i_load_loc_out   (reg_i_load_loc_out),
      .reg_j_load_loc_out   (reg_j_load_loc_out),
      .reg_load_addr_out    (reg_load_addr_out),
      .reg_m_load_size_out  (reg_m_load_size_out),
      .reg_n_load_size_out  (reg_n_load_size_out),
      .reg_load_element_out (reg_load_element_out),
      .load_busy_out        (load_busy_out),
      .load_done_out        (load_done_out),
      .load_error_out       (load_error_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 loading, 2 done; k counts accepted elements, element k lands at (k/N, k%N)
   int                 ph, mm, nn, k;
   logic               e_en, e_ready, e_busy, e_done, e_err;
   logic [MBITS:0]     e_i, e_m;
   logic [NBITS:0]     e_j, e_n;
   logic [MATRIX_REG_BITS:0] e_addr;
   logic [FPBITS:0]    e_el;

   task automatic model_reset();
      ph = 0; mm = 0; nn = 0; k = 0;
      e_en = 0; e_ready = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_i = '0; e_j = '0; e_m = '0; e_n = '0; e_addr = '0; e_el = '0;
   endtask

   task automatic check_outputs();
      check_eq("ready",   mem_load_ready_out,   e_ready);
      check_eq("en",      reg_load_en_out,      e_en);
      check_eq("i",       reg_i_load_loc_out,   e_i);
      check_eq("j",       reg_j_load_loc_out,   e_j);
      check_eq("addr",    reg_load_addr_out,    e_addr);
      check_eq("m_size",  reg_m_load_size_out,  e_m);
      check_eq("n_size",  reg_n_load_size_out,  e_n);
      check_eq("element", reg_load_element_out, e_el);
      check_eq("busy",    load_busy_out,        e_busy);
      check_eq("done",    load_done_out,        e_done);
      check_eq("error",   load_error_out,       e_err);
   endtask

   // Called at a falling edge: check last cycle's prediction, drive inputs, predict next cycle
   task automatic cycle(input bit req, input int rm, input int rn, input int ra, input bit v);
      logic [FPBITS:0] el;
      bit acc;
      check_outputs();
      el = $urandom;
      load_req_in         = req;
      mem_m_load_size_in  = rm[MBITS:0];
      mem_n_load_size_in  = rn[NBITS:0];
      mem_load_addr_in    = ra[MATRIX_REG_BITS:0];
      mem_load_valid_in   = v;
      mem_load_element_in = el;
      acc   = (ph == 1) && v;
      e_en  = acc;
      e_err = 0;
      if (acc) begin
         e_el = el;
         e_i  = MBITS'(k / nn);
         e_j  = NBITS'(k % nn);
         k++;
      end
      case (ph)
         0: if (req) begin
               if (rm == 0 || rn == 0) e_err = 1;
               else begin
                  mm = rm; nn = rn; k = 0; ph = 1;
                  e_m = rm[MBITS:0]; e_n = rn[NBITS:0]; e_addr = ra[MATRIX_REG_BITS:0];
               end
            end
         1: if (acc && k == mm * nn) ph = 2;
         default: ph = 0;
      endcase
      e_ready = (ph == 1);
      e_busy  = (ph != 0);
      e_done  = (ph == 2);
      @(negedge clk);
   endtask

   // mode 0: valid every cycle, 1: alternate, 2: random; abort_at >= 0 resets after that many accepts
   task automatic run_load(input int m, input int n, input int addr, input int mode,
                           input int abort_at, input bit spur);
      int  cyc;
      bit  v;
      bit  r;
      cycle(1'b1, m, n, addr, 1'b0);
      cyc = 0;
      while (ph != 0 && cyc < 200) begin
         if (abort_at >= 0 && k == abort_at && ph == 1) begin
            check_outputs();
            #2 rst_n = 1'b0;
            #1 model_reset();
            check_outputs();
            @(negedge clk);
            check_outputs();
            rst_n = 1'b1;
            return;
         end
         case (mode)
            0: v = 1'b1;
            1: v = cyc[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         r = spur && (($urandom_range(0, 2) == 0) || cyc == 1);
         cycle(r, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 7)), v);
         cyc++;
      end
      if (cyc >= 200) check_eq("load_timeout", load_busy_out, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      rst_n = 1'b0;
      load_req_in = 0; mem_m_load_size_in = '0; mem_n_load_size_in = '0;
      mem_load_addr_in = '0; mem_load_valid_in = 0; mem_load_element_in = '0;
      model_reset();
      #3 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      run_load(2, 3, 5, 0, -1, 1'b0);
      run_load(1, 1, 2, 0, -1, 1'b0);
      run_load(2, 2, 3, 1, -1, 1'b0);
      run_load(0, 3, 4, 0, -1, 1'b0);
      run_load(1, 1, 4, 0, -1, 1'b0);
      run_load(2, 2, 1, 0, 3, 1'b0);
      run_load(2, 2, 6, 0, -1, 1'b0);
      run_load(2, 3, 7, 0, -1, 1'b1);
      for (int t = 0; t < 30; t++)
         run_load(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 7)), 2, -1, 1'($urandom_range(0, 1)));
      check_outputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mpu_load.md
MPU_LOAD -- requirements
Module: mpu_load

Interface
REQ-001 SHALL have no module parameters; widths SHALL come from global_defs constants FPBITS, MBITS, NBITS, MATRIX_REG_BITS.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load_req_in  input  1  start a matrix load; sampled in LOAD_IDLE only.
REQ-005 mem_m_load_size_in  input  MBITS+1  total rows M; sampled with load_req_in.
REQ-006 mem_n_load_size_in  input  NBITS+1  total columns N; sampled with load_req_in.
REQ-007 mem_load_addr_in  input  MATRIX_REG_BITS+1  destination matrix register; sampled with load_req_in.
REQ-008 mem_load_valid_in  input  1  mem_load_element_in valid this cycle.
REQ-009 mem_load_element_in  input  FPBITS+1  matrix element, row-major order.
REQ-010 mem_load_ready_out  output  1  block accepts an element this cycle.
REQ-011 reg_load_en_out  output  1  register-file write strobe.
REQ-012 reg_i_load_loc_out  output  MBITS+1  row of element written.
REQ-013 reg_j_load_loc_out  output  NBITS+1  column of element written.
REQ-014 reg_load_addr_out  output  MATRIX_REG_BITS+1  destination register.
REQ-015 reg_m_load_size_out / reg_n_load_size_out  output  MBITS+1 / NBITS+1  captured dimensions, held until next accepted request.
REQ-016 reg_load_element_out  output  FPBITS+1  element written.
REQ-017 load_busy_out  output  1  high in LOAD_MATRIX and LOAD_DONE.
REQ-018 load_done_out  output  1  one-cycle completion pulse.
REQ-019 load_error_out  output  1  one-cycle pulse on rejected request.

Function
REQ-020 FSM states LOAD_IDLE, LOAD_MATRIX, LOAD_DONE; all outputs registered.
REQ-021 LOAD_IDLE: load_req_in with M>0 and N>0 -> capture sizes/addr, clear row_ptr/col_ptr, go LOAD_MATRIX next cycle.
REQ-022 LOAD_IDLE: load_req_in with M==0 or N==0 -> stay LOAD_IDLE, pulse load_error_out next cycle, captured sizes/addr unchanged.
REQ-023 load_req_in outside LOAD_IDLE ignored, no error.
REQ-024 mem_load_ready_out high exactly while in LOAD_MATRIX.
REQ-025 Element accepted when mem_load_valid_in && mem_load_ready_out; valid while ready low dropped.
REQ-026 Accept in cycle T -> reg_load_en_out high in T+1 with element, i=row_ptr, j=col_ptr at T, reg_load_addr_out=captured addr; else reg_load_en_out low.
REQ-027 Pointer advance per accept: col_ptr+1; at col_ptr==N-1 col_ptr->0, row_ptr+1; no wrap beyond M-1.
REQ-028 Accept at (M-1,N-1) -> LOAD_DONE next cycle; ready low from that cycle.
REQ-029 LOAD_DONE lasts one cycle, load_done_out high there (coincides with final write), then LOAD_IDLE; request earliest accepted in the following cycle.
REQ-030 Gaps in mem_load_valid_in stall pointers; no timeout.
REQ-031 reg_load_element_out, i, j hold last written values when reg_load_en_out low.

Reset
REQ-032 rst_n low -> immediately LOAD_IDLE, pointers 0, every output 0, regardless of clk.
REQ-033 Reset mid-load abandons transfer: no further writes, no done pulse; new request required after release.
REQ-034 First rising edge with rst_n high behaves as LOAD_IDLE.

Verification
REQ-035 2x3 load, addr 5, valid every cycle from ready -> six writes (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), each 1 cycle after accept, done with last write.
REQ-036 1x1 load -> one accept, write (0,0) and done same cycle, ready high one cycle only.
REQ-037 2x2 with valid low on alternate cycles -> four writes in order, pointers stall on gaps, done after 4th accept.
REQ-038 Request M=0,N=3 -> load_error_out one pulse, ready never high, no writes; then M=1,N=1 accepted.
REQ-039 rst_n low after 3 of 4 elements (2x2) -> all outputs 0 asynchronously, no done; fresh 2x2 load starts at (0,0).
REQ-040 load_req_in with different size/addr during LOAD_MATRIX -> ignored, original load completes unchanged.
